// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with a built-in tick prescaler and a run/pause FSM.
// Optional feature: define CDT_AUTO_RELOAD_EN to reload the last preset on the terminal tick.
module bcd_countdown_timer #(
    parameter int DIGITS   = 3,
    parameter int TICK_DIV = 50000000
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  running,
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state, state_next;
    logic [PW-1:0] presc, presc_next;
    logic [W-1:0]  count_next, clamped, decremented;
    logic          done_next;
    logic          tick, at_one, is_zero;

`ifdef CDT_AUTO_RELOAD_EN
    logic [W-1:0]  shadow;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr)
            shadow <= '0;
        else if (load)
            shadow <= clamped;
    end
`endif

    always_comb begin
        clamped = '0;
        for (int unsigned i = 0; i < DIGITS; i++)
            clamped[4*i +: 4] = (preset[4*i +: 4] > 4'd9) ? 4'd9 : preset[4*i +: 4];
    end

    // Borrow ripples upward: a zero digit becomes 9 and passes the borrow on.
    always_comb begin
        logic borrow;
        borrow      = 1'b1;
        decremented = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (bcd[4*i +: 4] == 4'd0) begin
                    decremented[4*i +: 4] = 4'd9;
                end else begin
                    decremented[4*i +: 4] = bcd[4*i +: 4] - 4'd1;
                    borrow                = 1'b0;
                end
            end
        end
    end

    assign at_one  = (bcd == W'(1));
    assign is_zero = (bcd == '0);
    assign tick    = (presc == PMAX) && (state == RUN) && !pause && !load;

    always_comb begin
        state_next = state;
        presc_next = presc;
        count_next = bcd;
        done_next  = 1'b0;
        if (load) begin
            count_next = clamped;
            presc_next = '0;
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    presc_next = '0;
                    if (start)
                        state_next = is_zero ? DONE : RUN;
                end
                RUN: begin
                    if (pause)
                        state_next = PAUSE;
                    // A pause landing on the last prescaler count holds it there.
                    if (tick)
                        presc_next = '0;
                    else if (presc != PMAX)
                        presc_next = presc + PW'(1);
                    if (tick) begin
                        if (at_one) begin
`ifdef CDT_AUTO_RELOAD_EN
                            count_next = shadow;
                            done_next  = 1'b1;
`else
                            count_next = '0;
                            state_next = DONE;
`endif
                        end else if (!is_zero) begin
                            count_next = decremented;
                        end
                    end
                end
                PAUSE: begin
                    if (start)
                        state_next = RUN;
                end
                DONE: begin
                    presc_next = '0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
        if (state_next == DONE)
            done_next = 1'b1;
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state   <= IDLE;
            presc   <= '0;
            bcd     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            presc   <= presc_next;
            bcd     <= count_next;
            running <= (state_next == RUN);
            done    <= done_next;
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios plus random pulses,
// compared every cycle against a decimal-arithmetic reference model.
module tb_bcd_countdown_timer;

    localparam int DIGITS = 3;
    localparam int DIV    = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic        clk = 1'b0;
    logic        aclr = 1'b0;
    logic        load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [11:0] preset = '0;
    logic [11:0] bcd;
    logic        running, done;

    int total = 0;
    int bad   = 0;

    int m_val, m_shadow, m_st, m_pre;
    bit m_pulse;

    bcd_countdown_timer #(.DIGITS(DIGITS), .TICK_DIV(DIV)) dut (
        .clk(clk), .aclr(aclr), .load(load), .preset(preset),
        .start(start), .pause(pause), .bcd(bcd), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int to_val(input logic [11:0] p);
        int v = 0;
        int scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(p[4*i +: 4]);
            if (d > 9) d = 9;
            v += d * scale;
            scale *= 10;
        end
        return v;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r = '0;
        int rem = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_val = 0; m_shadow = 0; m_st = S_IDLE; m_pre = 0; m_pulse = 0;
    endtask

    task automatic model_step(input bit l, input bit s, input bit p, input logic [11:0] pr);
        int ns = m_st;
        bit pulse = 0;
        if (l) begin
            m_val = to_val(pr); m_shadow = m_val; m_pre = 0; ns = S_IDLE;
        end else begin
            case (m_st)
                S_IDLE: begin
                    m_pre = 0;
                    if (s) ns = (m_val != 0) ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    bit tk = (m_pre == DIV - 1) && !p;
                    if (p) ns = S_PAUSE;
                    if (tk) m_pre = 0;
                    else if (m_pre < DIV - 1) m_pre++;
                    if (tk) begin
                        if (m_val == 1) begin
`ifdef CDT_AUTO_RELOAD_EN
                            m_val = m_shadow; pulse = 1;
`else
                            m_val = 0; ns = S_DONE;
`endif
                        end else if (m_val > 0) begin
                            m_val = m_val - 1;
                        end
                    end
                end
                S_PAUSE: if (s) ns = S_RUN;
                default: m_pre = 0;
            endcase
        end
        m_st = ns;
        m_pulse = pulse;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".bcd"}, 32'(bcd), 32'(to_bcd(m_val)));
        check({tag, ".running"}, 32'(running), 32'(m_st == S_RUN));
        check({tag, ".done"}, 32'(done), 32'((m_st == S_DONE) || m_pulse));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare 1 time unit later.
    task automatic step(input bit l, input bit s, input bit p, input logic [11:0] pr, input string tag);
        load = l; start = s; pause = p; preset = pr;
        @(posedge clk);
        model_step(l, s, p, pr);
        #1;
        check_model(tag);
        load = 0; start = 0; pause = 0;
    endtask

    task automatic idle_n(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, preset, tag);
    endtask

    initial begin
        model_reset();
        #2;
        check_model("reset");
        @(negedge clk);
        aclr = 1'b1;
        @(posedge clk); #1;

        // Async reset while running at 042
        step(1, 0, 0, 12'h043, "t1_load");
        step(0, 1, 0, 12'h043, "t1_start");
        idle_n(4, "t1_run");
        check("t1_at042", 32'(bcd), 32'h042);
        #2;
        aclr = 1'b0;
        model_reset();
        #1;
        check("t1_async_bcd", 32'(bcd), 32'h000);
        check("t1_async_running", 32'(running), 32'h0);
        check("t1_async_done", 32'(done), 32'h0);
        @(posedge clk); #1;
        check_model("t1_held");
        aclr = 1'b1;

        // Borrow across two digits
        step(1, 0, 0, 12'h102, "t2_load");
        step(0, 1, 0, 12'h102, "t2_start");
        idle_n(4, "t2_a");
        check("t2_101", 32'(bcd), 32'h101);
        idle_n(4, "t2_b");
        check("t2_100", 32'(bcd), 32'h100);
        idle_n(4, "t2_c");
        check("t2_099", 32'(bcd), 32'h099);
        idle_n(4, "t2_d");
        check("t2_098", 32'(bcd), 32'h098);

        // Terminal count and DONE stickiness
        step(1, 0, 0, 12'h002, "t3_load");
        step(0, 1, 0, 12'h002, "t3_start");
        idle_n(4, "t3_a");
        check("t3_001", 32'(bcd), 32'h001);
        idle_n(4, "t3_b");
`ifndef CDT_AUTO_RELOAD_EN
        check("t3_000", 32'(bcd), 32'h000);
        check("t3_done", 32'(done), 32'h1);
        check("t3_running", 32'(running), 32'h0);
        step(0, 1, 0, 12'h002, "t3_restart");
        step(0, 0, 1, 12'h002, "t3_pause");
        idle_n(6, "t3_hold");
        check("t3_done_held", 32'(done), 32'h1);
`endif

        // Pause keeps prescaler phase
        step(1, 0, 0, 12'h005, "t4_load");
        step(0, 1, 0, 12'h005, "t4_start");
        step(0, 0, 0, 12'h005, "t4_run");
        step(0, 0, 1, 12'h005, "t4_pause");
        idle_n(10, "t4_paused");
        check("t4_paused_bcd", 32'(bcd), 32'h005);
        check("t4_paused_running", 32'(running), 32'h0);
        step(0, 1, 0, 12'h005, "t4_resume");
        step(0, 0, 0, 12'h005, "t4_r1");
        check("t4_r1_bcd", 32'(bcd), 32'h005);
        step(0, 0, 0, 12'h005, "t4_r2");
        check("t4_r2_bcd", 32'(bcd), 32'h004);

        // Clamp on load, start from zero
        step(1, 0, 0, 12'h3A9, "t5_clamp");
        check("t5_399", 32'(bcd), 32'h399);
        step(1, 0, 0, 12'h000, "t5_zero");
        step(0, 1, 0, 12'h000, "t5_start0");
        check("t5_done", 32'(done), 32'h1);
        check("t5_bcd", 32'(bcd), 32'h000);
        idle_n(5, "t5_idle");

        // load wins over pause and start
        step(1, 0, 0, 12'h050, "t6_load");
        step(0, 1, 0, 12'h050, "t6_start");
        idle_n(6, "t6_run");
        step(1, 1, 1, 12'h123, "t6_all");
        check("t6_bcd", 32'(bcd), 32'h123);
        check("t6_running", 32'(running), 32'h0);
        check("t6_done", 32'(done), 32'h0);

        // Terminal behaviour repeated (reload pulses when the feature is built in)
        step(1, 0, 0, 12'h002, "t6_ld2");
        step(0, 1, 0, 12'h002, "t6_go");
        idle_n(24, "t6_cycle");

        // Random pulses against the model
        for (int n = 0; n < 1500; n++) begin
            int r = $urandom_range(0, 99);
            logic [11:0] pr;
            pr = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            step(r < 3, (r >= 3) && (r < 15), (r >= 12) && (r < 20), pr, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
